eq_scale_sched: RTL and testbench

EQ_SCALE_SCHED -- requirements
Module: eq_scale_sched

---
 rtl/eq_sched_pkg.sv | 47 ++++
 rtl/eq_mac_unit.sv | 54 +++++
 rtl/eq_scale_sched.sv | 141 ++++++++++++++
 tb/tb_eq_scale_sched.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eq_sched_pkg.sv
// ============================================================================
// Module      : eq_sched_pkg
// Description : Shared widths, state encoding and the sat16 helper for the
//               EQ scale scheduler. Clamping enabled by EQ_SCHED_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package eq_sched_pkg;

    localparam int NUM_BANDS_DEF = 5;
    localparam int FRAC_BITS_DEF = 11;
    localparam int DATA_W        = 16;
    localparam int GAIN_W        = 12;
    localparam int ACC_W         = 21;
    localparam int PROD_W        = 29;
    localparam int VOL_SHIFT     = 12;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_MAC   = 3'd1;
    localparam state_t ST_VOL_L = 3'd2;
    localparam state_t ST_VOL_R = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    localparam logic signed [ACC_W-1:0] C_SAT_MAX = 21'sd32767;
    localparam logic signed [ACC_W-1:0] C_SAT_MIN = -21'sd32768;

    // Reduce a channel accumulator to the 16-bit volume-stage operand.
    function automatic logic signed [DATA_W-1:0] sat16(input logic signed [ACC_W-1:0] acc);
`ifdef EQ_SCHED_SAT_EN
        if (acc > C_SAT_MAX) begin
            return 16'sh7FFF;
        end else if (acc < C_SAT_MIN) begin
            return 16'sh8000;
        end else begin
            return acc[DATA_W-1:0];
        end
`else
        return acc[DATA_W-1:0];
`endif
    endfunction

endpackage

`default_nettype wire

// File: rtl/eq_mac_unit.sv
// ============================================================================
// Module      : eq_mac_unit
// Description : Single shared signed 16x13 multiplier with operand muxing for
//               band-gain and volume products.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module eq_mac_unit
    import eq_sched_pkg::*;
#(
    parameter int NUM_BANDS = NUM_BANDS_DEF,
    parameter int FRAC_BITS = FRAC_BITS_DEF,
    parameter int IDX_W     = 3
) (
    input  logic [NUM_BANDS-1:0][DATA_W-1:0] band_lft,
    input  logic [NUM_BANDS-1:0][DATA_W-1:0] band_rght,
    input  logic [NUM_BANDS-1:0][GAIN_W-1:0] pot,
    input  logic [GAIN_W-1:0]                vol_pot,
    input  logic [IDX_W-1:0]                 band_idx,
    input  logic                             chan_rght,
    input  logic                             vol_phase,
    input  logic signed [ACC_W-1:0]          acc_lft,
    input  logic signed [ACC_W-1:0]          acc_rght,
    output logic signed [ACC_W-1:0]          band_term,
    output logic signed [DATA_W-1:0]         vol_term
);

    logic signed [DATA_W-1:0] w_op_a;
    logic [GAIN_W-1:0]        w_gain;
    logic signed [GAIN_W:0]   w_op_b;
    logic signed [PROD_W-1:0] w_prod;

    always_comb begin
        w_op_a = '0;
        w_gain = '0;
        if (vol_phase) begin
            w_op_a = sat16(chan_rght ? acc_rght : acc_lft);
            w_gain = vol_pot;
        end else begin
            w_op_a = chan_rght ? band_rght[band_idx] : band_lft[band_idx];
            w_gain = pot[band_idx];
        end
    end

    // Gains are unsigned; a zero sign bit keeps them positive in the signed product.
    assign w_op_b    = $signed({1'b0, w_gain});
    assign w_prod    = PROD_W'(w_op_a) * PROD_W'(w_op_b);
    assign band_term = ACC_W'(w_prod >>> FRAC_BITS);
    assign vol_term  = w_prod[VOL_SHIFT+DATA_W-1:VOL_SHIFT];

endmodule

`default_nettype wire

// File: rtl/eq_scale_sched.sv
// ============================================================================
// Module      : eq_scale_sched
// Description : Time-multiplexed 5-band EQ gain/volume scheduler, 13-cycle
//               latency. Optional accumulator clamp via EQ_SCHED_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module eq_scale_sched
    import eq_sched_pkg::*;
#(
    parameter int NUM_BANDS = NUM_BANDS_DEF,
    parameter int FRAC_BITS = FRAC_BITS_DEF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [NUM_BANDS-1:0][DATA_W-1:0] band_lft,
    input  logic [NUM_BANDS-1:0][DATA_W-1:0] band_rght,
    input  logic [NUM_BANDS-1:0][GAIN_W-1:0] pot,
    input  logic [GAIN_W-1:0]                vol_pot,
    output logic [DATA_W-1:0]                aud_out_lft,
    output logic [DATA_W-1:0]                aud_out_rght,
    output logic                             out_vld,
    output logic                             busy,
    output logic                             overrun
);

    localparam int CNT_W = $clog2(2 * NUM_BANDS);
    localparam int IDX_W = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(2 * NUM_BANDS - 1);
    localparam logic [CNT_W-1:0] C_CNT_RGHT = CNT_W'(NUM_BANDS);

    state_t                           r_state;
    logic [CNT_W-1:0]                 r_cnt;
    logic [NUM_BANDS-1:0][DATA_W-1:0] r_band_lft;
    logic [NUM_BANDS-1:0][DATA_W-1:0] r_band_rght;
    logic [NUM_BANDS-1:0][GAIN_W-1:0] r_pot;
    logic [GAIN_W-1:0]                r_vol_pot;
    logic signed [ACC_W-1:0]          r_acc_lft;
    logic signed [ACC_W-1:0]          r_acc_rght;
    logic signed [DATA_W-1:0]         r_vol_lft;

    logic                             w_mac_rght;
    logic [IDX_W-1:0]                 w_idx;
    logic                             w_vol_phase;
    logic                             w_chan_rght;
    logic signed [ACC_W-1:0]          w_band_term;
    logic signed [DATA_W-1:0]         w_vol_term;

    // Left-channel bands occupy the first half of the MAC sweep, right the second.
    assign w_mac_rght  = (r_cnt >= C_CNT_RGHT);
    assign w_idx       = w_mac_rght ? IDX_W'(r_cnt - C_CNT_RGHT) : IDX_W'(r_cnt);
    assign w_vol_phase = (r_state == ST_VOL_L) || (r_state == ST_VOL_R);
    assign w_chan_rght = w_vol_phase ? (r_state == ST_VOL_R) : w_mac_rght;
    assign busy        = (r_state != ST_IDLE);

    eq_mac_unit #(
        .NUM_BANDS (NUM_BANDS),
        .FRAC_BITS (FRAC_BITS),
        .IDX_W     (IDX_W)
    ) u_mac (
        .band_lft  (r_band_lft),
        .band_rght (r_band_rght),
        .pot       (r_pot),
        .vol_pot   (r_vol_pot),
        .band_idx  (w_idx),
        .chan_rght (w_chan_rght),
        .vol_phase (w_vol_phase),
        .acc_lft   (r_acc_lft),
        .acc_rght  (r_acc_rght),
        .band_term (w_band_term),
        .vol_term  (w_vol_term)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_band_lft   <= '0;
            r_band_rght  <= '0;
            r_pot        <= '0;
            r_vol_pot    <= '0;
            r_acc_lft    <= '0;
            r_acc_rght   <= '0;
            r_vol_lft    <= '0;
            aud_out_lft  <= '0;
            aud_out_rght <= '0;
            out_vld      <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            out_vld <= 1'b0;
            overrun <= start && (r_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_band_lft  <= band_lft;
                        r_band_rght <= band_rght;
                        r_pot       <= pot;
                        r_vol_pot   <= vol_pot;
                        r_acc_lft   <= '0;
                        r_acc_rght  <= '0;
                        r_cnt       <= '0;
                        r_state     <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    if (w_mac_rght) begin
                        r_acc_rght <= r_acc_rght + w_band_term;
                    end else begin
                        r_acc_lft <= r_acc_lft + w_band_term;
                    end
                    if (r_cnt == C_CNT_LAST) begin
                        r_state <= ST_VOL_L;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_VOL_L: begin
                    r_vol_lft <= w_vol_term;
                    r_state   <= ST_VOL_R;
                end
                ST_VOL_R: begin
                    aud_out_lft  <= r_vol_lft;
                    aud_out_rght <= w_vol_term;
                    out_vld      <= 1'b1;
                    r_state      <= ST_DONE;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_eq_scale_sched.sv
// ============================================================================
// Module      : tb_eq_scale_sched
// Description : Self-checking bench for eq_scale_sched against an arithmetic
//               reference model. Honours EQ_SCHED_SAT_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_eq_scale_sched;

    localparam int NB = 5;

    typedef struct {
        logic [NB-1:0][15:0] bl;
        logic [NB-1:0][15:0] br;
        logic [NB-1:0][11:0] p;
        logic [11:0]         v;
    } op_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [NB-1:0][15:0] band_lft;
    logic [NB-1:0][15:0] band_rght;
    logic [NB-1:0][11:0] pot;
    logic [11:0]         vol_pot;
    logic [15:0]         aud_out_lft;
    logic [15:0]         aud_out_rght;
    logic                out_vld;
    logic                busy;
    logic                overrun;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    eq_scale_sched dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .band_lft     (band_lft),
        .band_rght    (band_rght),
        .pot          (pot),
        .vol_pot      (vol_pot),
        .aud_out_lft  (aud_out_lft),
        .aud_out_rght (aud_out_rght),
        .out_vld      (out_vld),
        .busy         (busy),
        .overrun      (overrun)
    );

    // Channel result: sum of floor(band*pot/2^11), reduce to 16 bits, then floor(x*vol/2^12).
    function automatic logic [15:0] chan_ref(input logic [NB-1:0][15:0] b,
                                             input logic [NB-1:0][11:0] p,
                                             input logic [11:0] v);
        longint acc = 0;
        longint s;
        longint o;
        for (int i = 0; i < NB; i++) begin
            acc += (longint'($signed(b[i])) * longint'(p[i])) >>> 11;
        end
`ifdef EQ_SCHED_SAT_EN
        if (acc > 32767) s = 32767;
        else if (acc < -32768) s = -32768;
        else s = acc;
`else
        s = longint'($signed(acc[15:0]));
`endif
        o = (s * longint'(v)) >>> 12;
        return o[15:0];
    endfunction

    function automatic op_t rand_op(input int mode);
        op_t o;
        for (int i = 0; i < NB; i++) begin
            case (mode)
                1: begin
                    o.bl[i] = 16'(16'h7000 + $urandom_range(0, 4095));
                    o.br[i] = 16'(16'h7000 + $urandom_range(0, 4095));
                    o.p[i]  = 12'($urandom_range(3000, 4095));
                end
                2: begin
                    o.bl[i] = 16'(16'h8000 + $urandom_range(0, 4095));
                    o.br[i] = 16'(16'h8000 + $urandom_range(0, 4095));
                    o.p[i]  = 12'($urandom_range(3000, 4095));
                end
                default: begin
                    o.bl[i] = 16'($urandom);
                    o.br[i] = 16'($urandom);
                    o.p[i]  = ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom);
                end
            endcase
        end
        o.v = 12'($urandom_range(1, 4095));
        return o;
    endfunction

    function automatic op_t fill_op(input logic [15:0] bval, input logic [11:0] pval,
                                    input logic [11:0] vval);
        op_t o;
        for (int i = 0; i < NB; i++) begin
            o.bl[i] = bval;
            o.br[i] = bval;
            o.p[i]  = pval;
        end
        o.v = vval;
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input op_t o);
        band_lft  = o.bl;
        band_rght = o.br;
        pot       = o.p;
        vol_pot   = o.v;
    endtask

    // Caller is at a negedge; start is seen at the next posedge (cycle T).
    task automatic run_txn(input op_t o, input bit mutate, input string tag);
        logic [15:0] el;
        logic [15:0] er;
        int          early;
        int          idle;
        el    = chan_ref(o.bl, o.p, o.v);
        er    = chan_ref(o.br, o.p, o.v);
        early = 0;
        idle  = 0;
        drive(o);
        start = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (mutate) drive(rand_op(0));
            if (k < 13 && out_vld) early++;
            if (!busy) idle++;
        end
        chk({tag, "_vld_early"}, early, 0);
        chk({tag, "_busy"}, idle, 0);
        chk({tag, "_vld_t13"}, out_vld, 1'b1);
        chk({tag, "_lft"}, aud_out_lft, el);
        chk({tag, "_rght"}, aud_out_rght, er);
        @(negedge clk);
        chk({tag, "_vld_drop"}, out_vld, 1'b0);
        chk({tag, "_idle"}, busy, 1'b0);
        @(negedge clk);
        chk({tag, "_hold"}, {aud_out_lft, aud_out_rght}, {el, er});
    endtask

    initial begin
        op_t         a;
        op_t         b;
        logic [15:0] el;
        logic [15:0] er;
        logic [15:0] cap_l;
        logic [15:0] cap_r;
        int          bad;
        int          vld_cnt;
        int          vld_at;

        rst   = 1'b1;
        start = 1'b0;
        drive(fill_op(16'h0000, 12'h000, 12'h000));
        repeat (3) @(negedge clk);
        chk("rst_out", {aud_out_lft, aud_out_rght}, 32'h0);
        chk("rst_vld", out_vld, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ovr", overrun, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Unity gain on left band 0 only.
        a = fill_op(16'h0000, 12'h800, 12'hFFF);
        a.bl[0] = 16'h1000;
        run_txn(a, 1'b0, "unity");
        chk("unity_lft_k", aud_out_lft, 16'h0FFF);
        chk("unity_rght_k", aud_out_rght, 16'h0000);

        run_txn(fill_op(16'h7FFF, 12'hFFF, 12'hFFF), 1'b0, "pos_sat");
`ifdef EQ_SCHED_SAT_EN
        chk("pos_sat_k", {aud_out_lft, aud_out_rght}, {16'h7FF7, 16'h7FF7});
`endif
        run_txn(fill_op(16'h8000, 12'hFFF, 12'hFFF), 1'b0, "neg_sat");
`ifdef EQ_SCHED_SAT_EN
        chk("neg_sat_k", {aud_out_lft, aud_out_rght}, {16'h8008, 16'h8008});
`endif

        a = rand_op(0);
        for (int i = 0; i < NB; i++) a.p[i] = 12'h000;
        run_txn(a, 1'b0, "pot_zero");
        chk("pot_zero_k", {aud_out_lft, aud_out_rght}, 32'h0);

        a = rand_op(1);
        a.v = 12'h000;
        run_txn(a, 1'b1, "vol_zero_hold");
        chk("vol_zero_k", {aud_out_lft, aud_out_rght}, 32'h0);

        run_txn(rand_op(0), 1'b1, "hold");

        for (int t = 0; t < 20; t++) begin
            run_txn(rand_op(t % 3), 1'b0, $sformatf("rand%0d", t));
        end

        // Second start at T+5 must be dropped and flagged at T+6.
        a  = rand_op(0);
        el = chan_ref(a.bl, a.p, a.v);
        er = chan_ref(a.br, a.p, a.v);
        drive(a);
        start   = 1'b1;
        bad     = 0;
        vld_cnt = 0;
        vld_at  = -1;
        cap_l   = '0;
        cap_r   = '0;
        for (int k = 1; k <= 28; k++) begin
            @(negedge clk);
            if (overrun !== (k == 6)) bad++;
            if (out_vld) begin
                vld_cnt++;
                vld_at = k;
                cap_l  = aud_out_lft;
                cap_r  = aud_out_rght;
            end
            start = 1'b0;
            if (k == 5) begin
                drive(rand_op(0));
                start = 1'b1;
            end
        end
        chk("ovr_pulse", bad, 0);
        chk("ovr_vld_cnt", vld_cnt, 1);
        chk("ovr_vld_at", vld_at, 13);
        chk("ovr_result", {cap_l, cap_r}, {el, er});

        // Reset at T+7 aborts; restart at T+10 completes at T+23.
        run_txn(fill_op(16'h1000, 12'h800, 12'hFFF), 1'b0, "pre_rst");
        drive(rand_op(0));
        start = 1'b1;
        bad   = 0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (out_vld) bad++;
            if (k == 7) rst = 1'b1;
            if (k == 8) begin
                chk("mrst_busy", busy, 1'b0);
                chk("mrst_out", {aud_out_lft, aud_out_rght}, 32'h0);
                rst = 1'b0;
            end
        end
        chk("mrst_no_vld", bad, 0);
        @(negedge clk);
        b  = rand_op(0);
        el = chan_ref(b.bl, b.p, b.v);
        er = chan_ref(b.br, b.p, b.v);
        drive(b);
        start   = 1'b1;
        vld_cnt = 0;
        vld_at  = -1;
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            start = 1'b0;
            if (out_vld) begin
                vld_cnt++;
                vld_at = j + 10;
                cap_l  = aud_out_lft;
                cap_r  = aud_out_rght;
            end
        end
        chk("mrst_vld_cnt", vld_cnt, 1);
        chk("mrst_vld_at", vld_at, 23);
        chk("mrst_result", {cap_l, cap_r}, {el, er});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
